// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT datapath constants and bit-reverse helper
package fft_pkg;

  localparam int DW    = 10;
  localparam int N     = 64;
  localparam int AW    = $clog2(N);
  localparam int MAXAW = 16;

  // Reverse the low w bits of x. The full MAXAW-bit word is mirrored and then
  // shifted down so that bit i lands at w-1-i, keeping every index constant.
  function automatic logic [MAXAW-1:0] bitrev(input logic [MAXAW-1:0] x, input int w);
    logic [MAXAW-1:0] r;
    r = '0;
    for (int i = 0; i < MAXAW; i++) begin
      r[MAXAW-1-i] = x[i];
    end
    return r >> (MAXAW - w);
  endfunction

endpackage

// File: rtl/fft_frame_ram.sv
// rtl/fft_frame_ram.sv - 1W/1R frame memory with registered read port
module fft_frame_ram #(
  parameter int WIDTH = 20,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [2**AW];

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; output holds its last value between reads and clears on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fft_out_collector.sv
// rtl/fft_out_collector.sv - ping-pong frame collector behind the FFT output serializer
module fft_out_collector #(
  parameter int DW     = 10,
  parameter int N      = 64,
  parameter int BITREV = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din_valid,
  input  logic          din_sof,
  input  logic [DW-1:0] dinre,
  input  logic [DW-1:0] dinim,
  output logic          frame_ready,
  input  logic          rd_en,
  output logic [DW-1:0] doutre,
  output logic [DW-1:0] doutim,
  output logic          dout_valid,
  output logic          dout_last,
  output logic          overflow,
  output logic          sof_err
);

  import fft_pkg::*;

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_DROP = 1'b1;

  logic [0:0]      state;
  logic [AW-1:0]   wcnt;
  logic [AW-1:0]   rcnt;
  logic            wb;
  logic            rb;
  logic [1:0]      full;

  logic            resync;
  logic [AW-1:0]   widx;
  logic            frame_start;
  logic            drop_now;
  logic            wr_en;
  logic            wr_done;
  logic            drop_done;
  logic            rd_fire;
  logic            rd_done;
  logic [MAXAW-1:0] rev_full;
  logic [AW-1:0]   waddr_lo;
  logic [2*DW-1:0] rd_data;

  // Write/read event decode. A mid-frame SOF restarts the frame, so the
  // sample is treated as index 0 and goes through the normal frame-start check.
  always_comb begin
    resync      = din_valid && din_sof && (wcnt != '0);
    widx        = resync ? '0 : wcnt;
    frame_start = din_valid && (widx == '0);
    drop_now    = frame_start ? full[wb] : (state == S_DROP);
    wr_en       = din_valid && !drop_now;
    wr_done     = wr_en && (widx == LAST);
    drop_done   = din_valid && drop_now && (widx == LAST);
    rd_fire     = rd_en && full[rb];
    rd_done     = rd_fire && (rcnt == LAST);
  end

  assign rev_full = bitrev(MAXAW'(widx), AW);
  assign waddr_lo = (BITREV != 0) ? rev_full[AW-1:0] : widx;

  // Write-side counter, bank pointer, FILL/DROP state and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt     <= '0;
      wb       <= 1'b0;
      state    <= S_FILL;
      overflow <= 1'b0;
      sof_err  <= 1'b0;
    end else if (din_valid) begin
      wcnt <= widx + AW'(1);
      if (frame_start) begin
        state <= full[wb] ? S_DROP : S_FILL;
        if (full[wb]) begin
          overflow <= 1'b1;
        end
      end
      if (resync) begin
        sof_err <= 1'b1;
      end
      if (wr_done) begin
        wb <= ~wb;
      end
      if (drop_done) begin
        state <= S_FILL;
      end
    end
  end

  // Read-side counter, bank pointer and output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt       <= '0;
      rb         <= 1'b0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else begin
      dout_valid <= rd_fire;
      dout_last  <= rd_done;
      if (rd_fire) begin
        rcnt <= rcnt + AW'(1);
      end
      if (rd_done) begin
        rb <= ~rb;
      end
    end
  end

  // Bank full flags. A write can only complete into an empty bank and a read
  // only drains a full one, so the two updates never target the same bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
    end else begin
      if (wr_done) begin
        full[wb] <= 1'b1;
      end
      if (rd_done) begin
        full[rb] <= 1'b0;
      end
    end
  end

  assign frame_ready = full[rb];

  fft_frame_ram #(
    .WIDTH (2 * DW),
    .AW    (AW + 1)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr ({wb, waddr_lo}),
    .wr_data ({dinre, dinim}),
    .rd_en   (rd_fire),
    .rd_addr ({rb, rcnt}),
    .rd_data (rd_data)
  );

  assign doutre = rd_data[2*DW-1:DW];
  assign doutim = rd_data[DW-1:0];

endmodule

// File: doc/fft_out_collector.md
# fft_out_collector

Frame collector at the far end of the FFT datapath: consumes the serial complex sample stream produced by `output_unit` and assembles complete 64-point frames in a ping-pong buffer. Optionally undoes bit-reversed output order. Presents each finished frame to a downstream reader through a ready/read-enable handshake. It is the receiving counterpart of the serializer, and replaces free-running observation of `doutre`/`doutim` with framed, flow-controlled delivery.

## Interface
- `DW`, 10: sample component width (two's complement)
- `N`, 64: points per frame; power of two; `AW = log2(N)`
- `BITREV`, 1: 1 = write address is the bit-reverse of the arrival index; 0 = arrival order kept

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `din_valid`  in  1  sample present on `dinre`/`dinim`
- `din_sof`  in  1  first sample of a frame; only meaningful when `din_valid`=1
- `dinre`  in  DW  real part
- `dinim`  in  DW  imaginary part
- `frame_ready`  out  1  a complete frame is readable
- `rd_en`  in  1  pop one sample; ignored when `frame_ready`=0
- `doutre`  out  DW  real part, natural order
- `doutim`  out  DW  imaginary part
- `dout_valid`  out  1  `doutre`/`doutim` valid this cycle
- `dout_last`  out  1  with `dout_valid`: sample N-1 of the frame
- `overflow`  out  1  sticky; a frame was dropped because both banks were full
- `sof_err`  out  1  sticky; `din_sof` arrived mid-frame

## Operation
- Storage: two banks of N×(2·DW) each. Write bank pointer `wb`, read bank pointer `rb`, and `full[1:0]`.
- Write side:
  - Index counter `wcnt` (AW bits).
  - Each `din_valid` stores at `{wb, BITREV ? bitrev(wcnt) : wcnt}`, then `wcnt` increments and wraps at N-1 → 0.
  - Storing with `wcnt`=N-1 sets `full[wb]` and toggles `wb`.
- Frame-start check: when `din_valid` and `wcnt`=0, if `full[wb]`=1 the collector enters DROP.
  - In DROP, all N samples of that frame are counted but not written.
  - `overflow` is set.
  - DROP exits at the wrap.
- `din_sof`:
  - With `wcnt`≠0: `sof_err` is set and the partial frame is discarded (bank not marked full). The sample is stored as index 0 and `wcnt` becomes 1.
  - With `wcnt`=0: no effect.
- Write FSM states: FILL (normal), DROP. Transitions happen only at `wcnt`=0 sample acceptance.
- Read side:
  - `frame_ready` = `full[rb]`.
  - `rd_en` & `frame_ready` reads address `{rb, rcnt}`, then `rcnt` increments.
  - On the read with `rcnt`=N-1, `full[rb]` clears, `rb` toggles, and `dout_last` accompanies that sample.
- Simultaneous events:
  - Write-completion of one bank and read-completion of the other in the same cycle both take effect.
  - A bank becoming full in the same cycle the other drains: `frame_ready` stays high continuously.
- Data is passed through unmodified; no arithmetic, no width change.

## Timing
- Reset values:
  - `wcnt`, `rcnt`, `wb`, `rb`, `full` = 0; state FILL.
  - `frame_ready`, `dout_valid`, `dout_last`, `overflow`, `sof_err` = 0.
  - `doutre`, `doutim` = 0.
  - Buffer contents are not reset.
- Write: a sample accepted at edge t is readable in the same bank no earlier than t+1.
- Last sample of a frame accepted at edge t → `frame_ready`=1 after edge t (visible in cycle t+1).
- Read latency 1: `rd_en` sampled at edge t → `doutre`/`doutim`/`dout_valid` registered at edge t+1, held until the next edge. Without a new read, `dout_valid` returns to 0 and the data holds its last value.
- Full-rate streaming: with `rd_en` held high, N consecutive `dout_valid` cycles per frame. Back-to-back frames have no bubble when the next bank is already full.
- `rst` mid-frame: partial write frame and any unread frames are discarded; flags clear on the same edge.
- `overflow` and `sof_err` clear only on `rst`.

## Structure
- Shared package `fft_pkg`: `DW`, `N`, `AW`, and a `bitrev` function. `output_unit` and `input_unit` use the same function.
- One sub-module `fft_frame_ram`: dual-port (1W/1R) 2N×(2·DW) memory with registered read.
- Control (counters, bank flags, FSM) lives in `fft_out_collector`.

## Test plan
- Single frame, BITREV=1: inputs re=k, im=-k for arrival k=0..63, then `rd_en` held → `doutre` = bitrev6(k) in order; `dout_last` on the 64th; `frame_ready` drops the cycle after the last read.
- Ping-pong: 3 frames back-to-back, reads start after frame 1 at full rate → no loss, `overflow`=0, continuous `dout_valid` across the frame boundary.
- Overflow: 3 frames with no reads → frames 1 and 2 retained, frame 3 dropped, `overflow`=1. Reading then returns frames 1 and 2 only.
- SOF resync: `din_sof` at `wcnt`=20 → `sof_err`=1; the next frame of 64 samples starts at that sample and is readable with correct order.
- Reset mid-read: `rst` after 30 samples read → all outputs 0 next cycle; a new frame after reset reads correctly from index 0.
- Gapped input: `din_valid` toggling 1-0 with BITREV=0 → output equals input order; `frame_ready` asserts exactly one cycle after the 64th valid sample.
